// File: rtl/gba_eeprom_pkg.sv
// Shared types and constants for the GBA serial EEPROM master.
package gba_eeprom_pkg;

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR, WDATA, STOP, RHEAD, RDATA, POLL, DONE
  } state_e;

  localparam logic [1:0] CMD_RD = 2'b11;
  localparam logic [1:0] CMD_WR = 2'b10;

  localparam int unsigned HEAD_BITS  = 4;
  localparam int unsigned DATA_BITS  = 64;
  localparam int unsigned ADDR_SHORT = 6;
  localparam int unsigned ADDR_LONG  = 14;

endpackage

// File: rtl/gba_eeprom_beat.sv
// One serial beat: hold the request until accepted, then a single gap cycle
// in which done is raised and the EEPROM's returned bit is visible.
module gba_eeprom_beat (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic wr,
  input  logic tx_bit,
  output logic done,
  output logic rx_bit,
  output logic bus_valid,
  output logic bus_write,
  output logic bus_din,
  input  logic bus_ready,
  input  logic bus_dout
);

  logic valid_q, wr_q, din_q, gap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      wr_q    <= 1'b0;
      din_q   <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      gap_q <= valid_q & bus_ready;
      if (valid_q) begin
        if (bus_ready) valid_q <= 1'b0;
      end else if (start) begin
        valid_q <= 1'b1;
        wr_q    <= wr;
        din_q   <= wr & tx_bit;
      end
    end
  end

  assign done      = gap_q;
  assign rx_bit    = bus_dout;
  assign bus_valid = valid_q;
  assign bus_write = wr_q;
  assign bus_din   = din_q;

endmodule

// File: rtl/gba_eeprom_master.sv
// Sequences read/write block commands to a GBA serial EEPROM as single-bit
// beats, including the post-write busy poll with timeout.
module gba_eeprom_master
  import gba_eeprom_pkg::*;
#(
  parameter int unsigned POLL_MAX = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [13:0] cmd_addr,
  input  logic        addr_long,
  input  logic [63:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        bus_valid,
  output logic        bus_write,
  output logic        bus_din,
  input  logic        bus_ready,
  input  logic        bus_dout
);

  localparam int unsigned PW = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

  state_e         state_q, state_d;
  logic [6:0]     cnt_q, cnt_d;
  logic [PW-1:0]  poll_q, poll_d;
  logic           timeout_q, timeout_d;
  logic [63:0]    shift_q, shift_d, rdata_q, rdata_d;
  logic           write_q, long_q;
  logic [13:0]    addr_q;
  logic [63:0]    wdata_q;
  logic           start, tx_wr, tx_bit, done, rx_bit;
  logic [3:0]     alast;
  logic [1:0]     cmd_code;

  assign alast    = long_q ? 4'(ADDR_LONG - 1) : 4'(ADDR_SHORT - 1);
  assign cmd_code = write_q ? CMD_WR : CMD_RD;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    poll_d    = poll_q;
    timeout_d = timeout_q;
    shift_d   = shift_q;
    rdata_d   = rdata_q;
    start     = 1'b0;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        state_d   = CMD;
        cnt_d     = '0;
        timeout_d = 1'b0;
        start     = 1'b1;
      end
      CMD: if (done) begin
        start = 1'b1;
        if (cnt_q == 7'd1) begin
          state_d = ADDR;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 7'd1;
      end
      ADDR: if (done) begin
        start = 1'b1;
        if (cnt_q == {3'b000, alast}) begin
          state_d = write_q ? WDATA : STOP;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 7'd1;
      end
      WDATA: if (done) begin
        start = 1'b1;
        if (cnt_q == 7'(DATA_BITS - 1)) begin
          state_d = STOP;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 7'd1;
      end
      STOP: if (done) begin
        start   = 1'b1;
        state_d = write_q ? POLL : RHEAD;
        cnt_d   = '0;
        poll_d  = '0;
      end
      RHEAD: if (done) begin
        start = 1'b1;
        if (cnt_q == 7'(HEAD_BITS - 1)) begin
          state_d = RDATA;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 7'd1;
      end
      RDATA: if (done) begin
        shift_d = {shift_q[62:0], rx_bit};
        if (cnt_q == 7'(DATA_BITS - 1)) begin
          state_d = DONE;
          rdata_d = {shift_q[62:0], rx_bit};
        end else begin
          cnt_d = cnt_q + 7'd1;
          start = 1'b1;
        end
      end
      POLL: if (done) begin
        if (rx_bit) begin
          state_d   = DONE;
          timeout_d = 1'b0;
        end else if (poll_q == POLL_LAST) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else begin
          poll_d = poll_q + 1'b1;
          start  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bit for the beat being launched, chosen by the phase it belongs to.
    tx_wr  = 1'b0;
    tx_bit = 1'b0;
    unique case (state_d)
      CMD: begin
        tx_wr  = 1'b1;
        tx_bit = cmd_code[~cnt_d[0]];
      end
      ADDR: begin
        tx_wr  = 1'b1;
        tx_bit = addr_q[alast - cnt_d[3:0]];
      end
      WDATA: begin
        tx_wr  = 1'b1;
        tx_bit = wdata_q[~cnt_d[5:0]];
      end
      STOP:    tx_wr = 1'b1;
      default: tx_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      poll_q    <= '0;
      timeout_q <= 1'b0;
      shift_q   <= '0;
      rdata_q   <= '0;
      write_q   <= 1'b0;
      long_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      poll_q    <= poll_d;
      timeout_q <= timeout_d;
      shift_q   <= shift_d;
      rdata_q   <= rdata_d;
      if (state_q == IDLE && cmd_valid) begin
        write_q <= cmd_write;
        long_q  <= addr_long;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == DONE);
  assign rsp_timeout = rsp_valid & timeout_q;
  assign rsp_rdata   = rdata_q;

  gba_eeprom_beat u_beat (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .wr        (tx_wr),
    .tx_bit    (tx_bit),
    .done      (done),
    .rx_bit    (rx_bit),
    .bus_valid (bus_valid),
    .bus_write (bus_write),
    .bus_din   (bus_din),
    .bus_ready (bus_ready),
    .bus_dout  (bus_dout)
  );

endmodule
